// File: rtl/reset_pulse_seq.sv
// Reset pulse sequencer: accepts a pulse request, raises ASSERT_REQ toward a downstream reset
// generator, holds for the requested length once acknowledged, then waits out a guard interval.
module reset_pulse_seq #(
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  input  logic [LEN_WIDTH-1:0] REQ_LEN,
  output logic                 REQ_READY,
  output logic                 ASSERT_REQ,
  input  logic                 ASSERT_ACK,
  output logic                 DONE,
  output logic                 TIMEOUT,
  input  logic                 CLR_TIMEOUT
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StHold, StGuard} state_e;

  localparam logic [7:0]           AckTimeout = 8'(ACK_TIMEOUT);
  localparam logic [7:0]           Holdoff    = 8'(HOLDOFF);
  localparam logic [LEN_WIDTH-1:0] LenOne     = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]           timer_q, timer_d;
  logic                 from_hold_q, from_hold_d;
  logic                 assert_req_q, assert_req_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 timeout_set;
  logic                 accept;

  // Ready drops combinationally with RST so nothing is accepted while reset is held.
  assign REQ_READY = (state_q == StIdle) && RST;
  assign accept    = REQ_VALID && REQ_READY;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hold_cnt_d  = hold_cnt_q;
    timer_d     = timer_q;
    from_hold_d = from_hold_q;
    timeout_set = 1'b0;
    done_d      = 1'b0;

    // Counters only decrement while above one, so they can never wrap.
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWaitAck;
          len_d   = (REQ_LEN == '0) ? LenOne : REQ_LEN;
          timer_d = AckTimeout;
        end
      end
      StWaitAck: begin
        if (ASSERT_ACK) begin
          state_d    = StHold;
          hold_cnt_d = len_q;
        end else if (timer_q <= 8'd1) begin
          state_d     = StGuard;
          timer_d     = Holdoff;
          from_hold_d = 1'b0;
          timeout_set = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      StHold: begin
        if (hold_cnt_q <= LenOne) begin
          state_d     = StGuard;
          timer_d     = Holdoff;
          from_hold_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - LenOne;
        end
      end
      StGuard: begin
        if (timer_q <= 8'd1) begin
          state_d     = StIdle;
          done_d      = from_hold_q;
          from_hold_d = 1'b0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    assert_req_d = (state_d == StWaitAck) || (state_d == StHold);
    // A set in the same cycle as a clear takes priority.
    timeout_d    = timeout_set | (timeout_q & ~CLR_TIMEOUT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      len_q        <= '0;
      hold_cnt_q   <= '0;
      timer_q      <= '0;
      from_hold_q  <= 1'b0;
      assert_req_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      hold_cnt_q   <= hold_cnt_d;
      timer_q      <= timer_d;
      from_hold_q  <= from_hold_d;
      assert_req_q <= assert_req_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ASSERT_REQ = assert_req_q;
  assign DONE       = done_q;
  assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_reset_pulse_seq.sv
// Bench for reset_pulse_seq: timestamp-based reference model checked every cycle, directed
// scenarios pinned by literal traces, then randomized traffic with occasional async resets.
module tb_reset_pulse_seq;

  localparam int LEN_WIDTH   = 8;
  localparam int HOLDOFF     = 4;
  localparam int ACK_TIMEOUT = 15;

  logic                 CLK;
  logic                 RST;
  logic                 REQ_VALID;
  logic [LEN_WIDTH-1:0] REQ_LEN;
  logic                 REQ_READY;
  logic                 ASSERT_REQ;
  logic                 ASSERT_ACK;
  logic                 DONE;
  logic                 TIMEOUT;
  logic                 CLR_TIMEOUT;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  reset_pulse_seq #(
    .LEN_WIDTH  (LEN_WIDTH),
    .HOLDOFF    (HOLDOFF),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_LEN    (REQ_LEN),
    .REQ_READY  (REQ_READY),
    .ASSERT_REQ (ASSERT_REQ),
    .ASSERT_ACK (ASSERT_ACK),
    .DONE       (DONE),
    .TIMEOUT    (TIMEOUT),
    .CLR_TIMEOUT(CLR_TIMEOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: a request is a set of timestamps relative to its acceptance cycle.
  bit m_busy    = 1'b0;
  bit m_wait    = 1'b0;
  bit m_to      = 1'b0;
  int m_t_acc   = 0;
  int m_len     = 1;
  int m_alast   = 0;
  int m_end     = 0;
  int m_done_at = -1;

  always @(negedge CLK) begin
    int rel;
    bit e_ready, e_assert, e_done, set;
    if (!RST) begin
      check($sformatf("rst_ready c%0d", cyc), 32'(REQ_READY), 32'd0);
      check($sformatf("rst_assert c%0d", cyc), 32'(ASSERT_REQ), 32'd0);
      check($sformatf("rst_done c%0d", cyc), 32'(DONE), 32'd0);
      check($sformatf("rst_timeout c%0d", cyc), 32'(TIMEOUT), 32'd0);
      m_busy    = 1'b0;
      m_wait    = 1'b0;
      m_to      = 1'b0;
      m_done_at = -1;
    end else begin
      rel = cyc - m_t_acc;
      if (m_busy && !m_wait && rel >= m_end) m_busy = 1'b0;
      e_ready  = !m_busy;
      e_assert = m_busy && (m_wait || rel <= m_alast);
      e_done   = (cyc == m_done_at);
      check($sformatf("ready c%0d", cyc), 32'(REQ_READY), 32'(e_ready));
      check($sformatf("assert_req c%0d", cyc), 32'(ASSERT_REQ), 32'(e_assert));
      check($sformatf("done c%0d", cyc), 32'(DONE), 32'(e_done));
      check($sformatf("timeout c%0d", cyc), 32'(TIMEOUT), 32'(m_to));
      set = 1'b0;
      if (m_busy && m_wait) begin
        if (ASSERT_ACK) begin
          m_wait    = 1'b0;
          m_alast   = rel + m_len;
          m_end     = rel + m_len + HOLDOFF + 1;
          m_done_at = m_t_acc + m_end;
        end else if (rel == ACK_TIMEOUT) begin
          m_wait  = 1'b0;
          m_alast = rel;
          m_end   = rel + HOLDOFF + 1;
          set     = 1'b1;
        end
      end
      if (e_ready && REQ_VALID) begin
        m_busy  = 1'b1;
        m_wait  = 1'b1;
        m_t_acc = cyc;
        m_len   = (REQ_LEN == '0) ? 1 : int'(REQ_LEN);
      end
      m_to = set | (m_to & !CLR_TIMEOUT);
    end
  end

  // Runs nrel cycles starting at posedge+1; bit r of each mask/trace refers to relative cycle r.
  task automatic run_seq(input int nrel, input logic [7:0] len, input logic [31:0] vmask,
                         input logic [31:0] amask, input logic [31:0] cmask,
                         output logic [31:0] a_tr, output logic [31:0] d_tr,
                         output logic [31:0] r_tr, output logic [31:0] t_tr);
    a_tr = '0;
    d_tr = '0;
    r_tr = '0;
    t_tr = '0;
    for (int r = 0; r < nrel; r++) begin
      REQ_VALID   = vmask[r];
      REQ_LEN     = len;
      ASSERT_ACK  = amask[r];
      CLR_TIMEOUT = cmask[r];
      @(negedge CLK);
      a_tr[r] = ASSERT_REQ;
      d_tr[r] = DONE;
      r_tr[r] = REQ_READY;
      t_tr[r] = TIMEOUT;
      @(posedge CLK);
      #1;
    end
    REQ_VALID   = 1'b0;
    ASSERT_ACK  = 1'b0;
    CLR_TIMEOUT = 1'b0;
  endtask

  logic [31:0] a_tr, d_tr, r_tr, t_tr;
  int          done_cnt;
  int          done_rel;

  initial begin
    RST         = 1'b1;
    REQ_VALID   = 1'b0;
    REQ_LEN     = '0;
    ASSERT_ACK  = 1'b0;
    CLR_TIMEOUT = 1'b0;
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_outputs", {28'd0, REQ_READY, ASSERT_REQ, DONE, TIMEOUT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // Nominal: length 3, ack high from relative cycle 2.
    run_seq(13, 8'd3, 32'h1, 32'h1FFC, 32'h0, a_tr, d_tr, r_tr, t_tr);
    check("nominal_assert", a_tr, 32'h0000_003E);
    check("nominal_done", d_tr, 32'h0000_0400);
    check("nominal_ready", r_tr, 32'h0000_1C01);

    // Zero length behaves as length 1.
    run_seq(13, 8'd0, 32'h1, 32'h1FFC, 32'h0, a_tr, d_tr, r_tr, t_tr);
    check("zero_assert", a_tr, 32'h0000_000E);
    check("zero_done", d_tr, 32'h0000_0100);
    check("zero_ready", r_tr, 32'h0000_1F01);

    // Ack never arrives.
    run_seq(22, 8'd3, 32'h1, 32'h0, 32'h0, a_tr, d_tr, r_tr, t_tr);
    check("timeout_assert", a_tr, 32'h0000_FFFE);
    check("timeout_done", d_tr, 32'h0);
    check("timeout_ready", r_tr, 32'h0030_0001);
    check("timeout_flag", t_tr, 32'h003F_0000);

    run_seq(3, 8'd0, 32'h0, 32'h0, 32'h1, a_tr, d_tr, r_tr, t_tr);
    check("timeout_clear", t_tr, 32'h1);

    // Clear asserted in the very cycle the timeout fires.
    run_seq(22, 8'd3, 32'h1, 32'h0, 32'h0000_8000, a_tr, d_tr, r_tr, t_tr);
    check("set_wins", t_tr, 32'h003F_0000);
    run_seq(3, 8'd0, 32'h0, 32'h0, 32'h1, a_tr, d_tr, r_tr, t_tr);
    check("timeout_clear2", t_tr, 32'h1);

    // Back-to-back: second request in the DONE cycle.
    run_seq(22, 8'd3, 32'h401, 32'h003F_F3FC, 32'h0, a_tr, d_tr, r_tr, t_tr);
    check("b2b_assert", a_tr, 32'h0000_F83E);
    check("b2b_done", d_tr, 32'h0010_0400);
    check("b2b_ready", r_tr, 32'h0030_0401);

    // Requests during HOLD and GUARD are ignored.
    run_seq(13, 8'd3, 32'h91, 32'h1FFC, 32'h0, a_tr, d_tr, r_tr, t_tr);
    check("ignore_assert", a_tr, 32'h0000_003E);
    check("ignore_done", d_tr, 32'h0000_0400);
    check("ignore_ready", r_tr, 32'h0000_1C01);

    // Reset in relative cycle 4 (mid-HOLD).
    run_seq(4, 8'd3, 32'h1, 32'hC, 32'h0, a_tr, d_tr, r_tr, t_tr);
    check("mid_hold_assert_before", 32'(a_tr[3]), 32'd1);
    ASSERT_ACK = 1'b1;
    #2 RST = 1'b0;
    #1;
    check("mid_hold_async", {30'd0, ASSERT_REQ, REQ_READY}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    run_seq(12, 8'd3, 32'h0, 32'hFFF, 32'h0, a_tr, d_tr, r_tr, t_tr);
    check("after_reset_ready", r_tr, 32'h0000_0FFF);
    check("after_reset_done", d_tr, 32'h0);
    check("after_reset_assert", a_tr, 32'h0);

    // Maximum length: hold counter must not wrap.
    done_cnt = 0;
    done_rel = -1;
    for (int r = 0; r < 266; r++) begin
      REQ_VALID  = (r == 0);
      REQ_LEN    = 8'd255;
      ASSERT_ACK = (r >= 2);
      @(negedge CLK);
      if (r == 257) check("maxlen_assert_last", 32'(ASSERT_REQ), 32'd1);
      if (r == 258) check("maxlen_assert_low", 32'(ASSERT_REQ), 32'd0);
      if (DONE) begin
        done_cnt++;
        done_rel = r;
      end
      @(posedge CLK);
      #1;
    end
    check("maxlen_done_cycle", 32'(done_rel), 32'd262);
    check("maxlen_done_count", 32'(done_cnt), 32'd1);

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      REQ_VALID   = 1'($urandom_range(0, 1));
      REQ_LEN     = ($urandom_range(0, 29) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      ASSERT_ACK  = ($urandom_range(0, 9) == 0);
      CLR_TIMEOUT = ($urandom_range(0, 15) == 0);
      if (!RST) begin
        RST = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        #2 RST = 1'b0;
      end
      @(posedge CLK);
      #1;
    end
    RST         = 1'b1;
    REQ_VALID   = 1'b0;
    ASSERT_ACK  = 1'b0;
    CLR_TIMEOUT = 1'b0;
    repeat (4) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
